// File: rtl/strobe_period_sequencer.sv
// Sequencer that configures, starts and stops an attached counter_with_strobe,
// turning its strobe into qualified ticks and finite-burst completion pulses.
module strobe_period_sequencer #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_count,
  output logic               cnt_rst,
  output logic               cnt_enable,
  output logic [WIDTH-1:0]   cnt_reset_value,
  input  logic               cnt_ready,
  input  logic               cnt_strobe,
  output logic               tick,
  output logic [BURST_W-1:0] tick_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_RUN} state_t;

  if (LATENCY < 1) begin : g_latency_check
    $error("strobe_period_sequencer: LATENCY must be at least 1");
  end

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic [WIDTH-1:0]   shadow_period_q, shadow_period_d;
  logic [BURST_W-1:0] shadow_count_q, shadow_count_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0]   reset_value_q, reset_value_d;
  logic [BURST_W-1:0] tick_count_q, tick_count_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;

  logic               handshake;
  logic               final_strobe;
  logic               reload_now;
  logic [WIDTH-1:0]   period_clamped;

  assign period_clamped = (cfg_period == '0) ? WIDTH'(1) : cfg_period;
  assign cfg_ready      = ((state_q == S_IDLE) || (state_q == S_RUN)) && !pending_q;
  assign handshake      = cfg_valid && cfg_ready;

  // A strobe ending a finite burst wins over a reload; the pending config is then re-armed from IDLE.
  assign final_strobe = (state_q == S_RUN) && cnt_strobe && (remaining_q == BURST_W'(1));
  assign reload_now   = (state_q == S_RUN) && cnt_strobe && pending_q && run && !final_strobe;

  // The new period is presented to the counter during the reload cycle itself.
  assign cnt_reset_value = reload_now ? shadow_period_q : reset_value_q;
  assign tick            = tick_q;
  assign tick_count      = tick_count_q;
  assign done            = done_q;
  assign busy            = (state_q != S_IDLE);

  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    shadow_period_d = shadow_period_q;
    shadow_count_d  = shadow_count_q;
    remaining_d     = remaining_q;
    reset_value_d   = reset_value_q;
    tick_count_d    = tick_count_q;
    tick_d          = cnt_strobe && (state_q == S_RUN);
    done_d          = 1'b0;
    cnt_rst         = 1'b0;
    cnt_enable      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          reset_value_d = shadow_period_q;
          remaining_d   = shadow_count_q;
          tick_count_d  = '0;
          pending_d     = 1'b0;
          state_d       = S_ARM;
        end else if (handshake) begin
          reset_value_d = period_clamped;
          remaining_d   = cfg_count;
          tick_count_d  = '0;
          state_d       = S_ARM;
        end
      end
      S_ARM: begin
        cnt_rst = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_ready && run) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_enable = cnt_ready && run && !reload_now && !final_strobe;
        if (cnt_strobe) begin
          tick_count_d = tick_count_q + BURST_W'(1);
          if (remaining_q != '0) begin
            remaining_d = remaining_q - BURST_W'(1);
          end
        end
        if (handshake) begin
          shadow_period_d = period_clamped;
          shadow_count_d  = cfg_count;
          pending_d       = 1'b1;
        end
        // Losing run takes priority: stop without done and drop any queued config.
        if (!run) begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
        end else if (final_strobe) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (reload_now) begin
          reset_value_d = shadow_period_q;
          remaining_d   = shadow_count_q;
          tick_count_d  = '0;
          pending_d     = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pending_q       <= 1'b0;
      shadow_period_q <= '0;
      shadow_count_q  <= '0;
      remaining_q     <= '0;
      reset_value_q   <= '0;
      tick_count_q    <= '0;
      tick_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      shadow_period_q <= shadow_period_d;
      shadow_count_q  <= shadow_count_d;
      remaining_q     <= remaining_d;
      reset_value_q   <= reset_value_d;
      tick_count_q    <= tick_count_d;
      tick_q          <= tick_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_strobe_period_sequencer.sv
// Scoreboard bench for strobe_period_sequencer driving a small behavioural
// stand-in for counter_with_strobe.
module tb_strobe_period_sequencer;

  localparam int WIDTH   = 32;
  localparam int BURST_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               run = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [WIDTH-1:0]   cfg_period = '0;
  logic [BURST_W-1:0] cfg_count = '0;
  logic               cnt_rst;
  logic               cnt_enable;
  logic [WIDTH-1:0]   cnt_reset_value;
  logic               cnt_ready;
  logic               cnt_strobe;
  logic               tick;
  logic [BURST_W-1:0] tick_count;
  logic               busy;
  logic               done;

  strobe_period_sequencer #(.WIDTH(WIDTH), .LATENCY(1), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_count(cfg_count),
    .cnt_rst(cnt_rst), .cnt_enable(cnt_enable), .cnt_reset_value(cnt_reset_value),
    .cnt_ready(cnt_ready), .cnt_strobe(cnt_strobe),
    .tick(tick), .tick_count(tick_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Counter stand-in: strobe after `period` enabled cycles, ready a few cycles after its reset.
  logic [WIDTH-1:0] mCnt = '0;
  logic [WIDTH-1:0] mPer = '1;
  int               mReadyDly = 3;

  assign cnt_ready  = (mReadyDly == 0);
  assign cnt_strobe = (mCnt == mPer);

  always @(posedge clk) begin
    if (rst || cnt_rst) begin
      mCnt      <= '0;
      mPer      <= rst ? '1 : cnt_reset_value;
      mReadyDly <= 3;
    end else begin
      if (mReadyDly > 0) mReadyDly <= mReadyDly - 1;
      if (cnt_strobe) begin
        if (cnt_enable) begin
          mCnt <= 1;
        end else begin
          mCnt <= '0;
          mPer <= cnt_reset_value;
        end
      end else if (cnt_enable) begin
        mCnt <= mCnt + 1;
      end
    end
  end

  typedef struct {
    logic [BURST_W-1:0] tc;
    logic               dn;
    int                 gap;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  failures = 0;
  int  ticksSeen = 0;
  int  doneSeen = 0;
  int  rstPulses = 0;
  int  cycle = 0;
  int  lastTick = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic pushExp(input int tc, input bit dn, input int gap);
    expT e;
    e.tc  = BURST_W'(tc);
    e.dn  = dn;
    e.gap = gap;
    expQ.push_back(e);
  endtask

  // Monitor: every tick the DUT presents is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (cnt_rst) rstPulses++;
      if (cnt_enable) checkOutput("enable_needs_ready", cnt_ready, 1);
      if (done) begin
        doneSeen++;
        checkOutput("done_needs_tick", tick, 1);
      end
      if (tick) begin
        ticksSeen++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_tick: got tick_count=%0d expected no tick", tick_count);
        end else begin
          expT e;
          e = expQ.pop_front();
          checkOutput("tick_count", tick_count, e.tc);
          checkOutput("done_with_tick", done, e.dn);
          if (e.gap > 0) checkOutput("tick_gap_ok", ((cycle - lastTick) >= e.gap), 1);
        end
        lastTick = cycle;
      end
    end
    cycle++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int period, input int count);
    bit ok;
    ok = 0;
    cfg_period = WIDTH'(period);
    cfg_count  = BURST_W'(count);
    cfg_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cfg_ready) begin
        ok = 1;
        break;
      end
      step();
    end
    checkOutput("cfg_handshake_timeout", ok, 1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic waitTicks(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (ticksSeen >= target) begin
        ok = 1;
        break;
      end
      step();
    end
    checkOutput("wait_ticks_timeout", ok, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cnt_rst"}, cnt_rst, 0);
    checkOutput({tag, "_cnt_enable"}, cnt_enable, 0);
    checkOutput({tag, "_tick"}, tick, 0);
    checkOutput({tag, "_tick_count"}, tick_count, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_reset_value"}, cnt_reset_value, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  initial begin
    int baseT, baseD, baseR;
    repeat (3) step();
    rst = 1'b0;
    step();
    checkResetOutputs("reset");

    // Finite burst: period 4, three ticks
    run = 1'b1;
    baseT = ticksSeen; baseD = doneSeen; baseR = rstPulses;
    pushExp(1, 0, 0); pushExp(2, 0, 4); pushExp(3, 1, 4);
    applyStimulus(4, 3);
    checkOutput("arm_cnt_rst", cnt_rst, 1);
    checkOutput("arm_reset_value", cnt_reset_value, 4);
    checkOutput("arm_busy", busy, 1);
    step();
    checkOutput("wait_cnt_rst_low", cnt_rst, 0);
    checkOutput("wait_enable_low", cnt_enable, 0);
    waitTicks(baseT + 3);
    step();
    checkOutput("burst_busy_low", busy, 0);
    checkOutput("burst_enable_low", cnt_enable, 0);
    checkOutput("burst_done_count", doneSeen - baseD, 1);
    checkOutput("burst_rst_pulses", rstPulses - baseR, 1);

    // Continuous period 5, then period 9 reloaded on the next strobe
    baseT = ticksSeen; baseD = doneSeen;
    pushExp(1, 0, 0); pushExp(2, 0, 5);
    applyStimulus(5, 0);
    waitTicks(baseT + 2);
    pushExp(0, 0, 5); pushExp(1, 0, 9); pushExp(2, 0, 9);
    applyStimulus(9, 0);
    checkOutput("pending_cfg_ready_low", cfg_ready, 0);
    checkOutput("pending_value_held", cnt_reset_value, 5);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (cnt_strobe) begin
          seen = 1;
          break;
        end
        step();
      end
      checkOutput("reload_strobe_seen", seen, 1);
      checkOutput("reload_enable_low", cnt_enable, 0);
      checkOutput("reload_value_new", cnt_reset_value, 9);
    end
    waitTicks(baseT + 5);
    run = 1'b0;
    step();
    checkOutput("cont_stop_busy", busy, 0);
    checkOutput("cont_tick_count_held", tick_count, 2);
    checkOutput("cont_no_done", doneSeen - baseD, 0);
    checkOutput("cont_reset_value_kept", cnt_reset_value, 9);
    run = 1'b1;

    // Period 0 is clamped to 1
    baseT = ticksSeen; baseD = doneSeen;
    pushExp(1, 0, 0); pushExp(2, 1, 1);
    applyStimulus(0, 2);
    checkOutput("clamp_reset_value", cnt_reset_value, 1);
    waitTicks(baseT + 2);
    step();
    checkOutput("clamp_busy_low", busy, 0);
    checkOutput("clamp_done_count", doneSeen - baseD, 1);

    // run dropped mid-burst with a config pending
    baseT = ticksSeen; baseD = doneSeen; baseR = rstPulses;
    pushExp(1, 0, 0); pushExp(2, 0, 6); pushExp(3, 0, 6); pushExp(4, 0, 6);
    applyStimulus(6, 10);
    waitTicks(baseT + 4);
    applyStimulus(7, 1);
    run = 1'b0;
    #1;
    checkOutput("drop_enable_same_cycle", cnt_enable, 0);
    step();
    checkOutput("drop_idle_next", busy, 0);
    repeat (4) step();
    checkOutput("drop_pending_discarded", busy, 0);
    checkOutput("drop_cfg_ready", cfg_ready, 1);
    checkOutput("drop_tick_count_held", tick_count, 4);
    checkOutput("drop_reset_value", cnt_reset_value, 6);
    checkOutput("drop_no_done", doneSeen - baseD, 0);
    checkOutput("drop_rst_pulses", rstPulses - baseR, 1);
    run = 1'b1;

    // Pending config landing on the final strobe of a burst
    baseT = ticksSeen; baseD = doneSeen; baseR = rstPulses;
    pushExp(1, 0, 0); pushExp(2, 1, 4); pushExp(1, 1, 0);
    applyStimulus(4, 2);
    waitTicks(baseT + 1);
    applyStimulus(3, 1);
    waitTicks(baseT + 3);
    step();
    checkOutput("chain_busy_low", busy, 0);
    checkOutput("chain_done_count", doneSeen - baseD, 2);
    checkOutput("chain_rst_pulses", rstPulses - baseR, 2);
    checkOutput("chain_reset_value", cnt_reset_value, 3);

    // rst in WAIT, then in RUN, then a normal config
    applyStimulus(5, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkResetOutputs("rst_wait");
    baseT = ticksSeen;
    pushExp(1, 0, 0);
    applyStimulus(5, 0);
    waitTicks(baseT + 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkResetOutputs("rst_run");
    baseT = ticksSeen; baseD = doneSeen;
    pushExp(1, 1, 0);
    applyStimulus(2, 1);
    waitTicks(baseT + 1);
    step();
    checkOutput("post_rst_done", doneSeen - baseD, 1);
    checkOutput("post_rst_busy", busy, 0);

    repeat (10) step();
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
